lcd_hex_display: RTL

Downstream consumer of the top level's debug word: takes a 32-bit value (debug_reg1 from the Space Invaders processor) and shows it as eight uppercase hex digits on line 1 of the DE2 HD44780 16x2 character LCD. Owns the power-up initialisation, per-byte enable strobing and command/clear wait timing. Drives the top-level pins lcd_data, lcd_rw, lcd_en, lcd_rs, lcd_on and lcd_blon directly.

---
 rtl/lcd_hex_display.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_hex_display.sv
// lcd_hex_display
//
// Shows a 32-bit debug word as eight uppercase hex digits on line 1 of an
// HD44780-compatible 16x2 character LCD. Handles the power-up delay, the
// controller initialisation (0x38, 0x0C, 0x01, 0x06), per-byte enable
// strobing and the command/clear wait times. Only values that differ from
// what is already on screen trigger a refresh.
//
// Optional feature: define LCD_PREFIX_EN to write "0x" in front of the
// digits on every refresh (10 characters instead of 8).
//
// Ports:
//   clk_in      system clock, all logic on the rising edge
//   reset       synchronous, active-high
//   write_en    request to display write_data (sampled every cycle)
//   write_data  32-bit value to display
//   busy        high while powering up, initialising or refreshing
//   lcd_data    LCD data bus
//   lcd_rw      tied low (write only)
//   lcd_en      LCD enable strobe
//   lcd_rs      0 = command, 1 = character
//   lcd_on      tied high
//   lcd_blon    tied high
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_POWERUP | idle delay after reset, lcd_en held low
// ST_INIT    | sending the four initialisation commands
// ST_IDLE    | waiting for a new value to show
// ST_REFRESH | sending 0x80 followed by the characters
//
// phase      | meaning (per byte, used in ST_INIT and ST_REFRESH)
// -----------+-----------------------------------------------------------
// PH_SETUP   | one cycle with rs/data driven, lcd_en low
// PH_PULSE   | lcd_en high for EN_PULSE_CYC cycles
// PH_WAIT    | lcd_en low for CMD_WAIT_CYC (CLEAR_WAIT_CYC after 0x01)

module lcd_hex_display #(
    parameter int POWERUP_CYC    = 1000000,
    parameter int EN_PULSE_CYC   = 16,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        write_en,
    input  logic [31:0] write_data,
    output logic        busy,
    output logic [7:0]  lcd_data,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_rs,
    output logic        lcd_on,
    output logic        lcd_blon
);

    localparam int MAX_A   = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_B   = (EN_PULSE_CYC > CMD_WAIT_CYC) ? EN_PULSE_CYC : CMD_WAIT_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    // Down-counters are loaded with N-1, so they never need to hold MAX_CYC.
    localparam int TMR_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [TMR_W-1:0] T_POWERUP = TMR_W'(POWERUP_CYC - 1);
    localparam logic [TMR_W-1:0] T_PULSE   = TMR_W'(EN_PULSE_CYC - 1);
    localparam logic [TMR_W-1:0] T_CMD     = TMR_W'(CMD_WAIT_CYC - 1);
    localparam logic [TMR_W-1:0] T_CLEAR   = TMR_W'(CLEAR_WAIT_CYC - 1);

`ifdef LCD_PREFIX_EN
    localparam int REF_BYTES = 11;
`else
    localparam int REF_BYTES = 9;
`endif
    localparam logic [3:0] LAST_INIT = 4'd3;
    localparam logic [3:0] LAST_REF  = 4'(REF_BYTES - 1);

    typedef enum logic [1:0] {ST_POWERUP, ST_INIT, ST_IDLE, ST_REFRESH} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

    state_t           state;
    phase_t           phase;
    logic [TMR_W-1:0] timer;
    logic [3:0]       byte_idx;
    logic             pending;
    logic [31:0]      pend_val;
    logic             shown_valid;
    logic [31:0]      shown_val;

    logic [3:0]       next_idx;
    logic [7:0]       next_byte;
    logic             last_byte;

    assign lcd_rw   = 1'b0;
    assign lcd_on   = 1'b1;
    assign lcd_blon = 1'b1;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] init_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h38;
            4'd1:    return 8'h0C;
            4'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Byte idx of a refresh: 0x80, optional "0x", then digits MSB nibble first.
    function automatic logic [7:0] refresh_byte(input logic [3:0] idx, input logic [31:0] val);
        logic [3:0]  digit;
        logic [31:0] sh;
`ifdef LCD_PREFIX_EN
        digit = idx - 4'd3;
`else
        digit = idx - 4'd1;
`endif
        sh = val << {digit, 2'b00};
        if (idx == 4'd0)
            return 8'h80;
`ifdef LCD_PREFIX_EN
        if (idx == 4'd1)
            return 8'h30;
        if (idx == 4'd2)
            return 8'h78;
`endif
        return hex_ascii(sh[31:28]);
    endfunction

    always_comb begin
        next_idx  = byte_idx + 4'd1;
        next_byte = (state == ST_INIT) ? init_byte(next_idx) : refresh_byte(next_idx, shown_val);
        last_byte = (state == ST_INIT) ? (byte_idx == LAST_INIT) : (byte_idx == LAST_REF);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state       <= ST_POWERUP;
            phase       <= PH_SETUP;
            timer       <= T_POWERUP;
            byte_idx    <= 4'd0;
            pending     <= 1'b0;
            pend_val    <= 32'h0;
            shown_valid <= 1'b0;
            shown_val   <= 32'h0;
            lcd_data    <= 8'h00;
            lcd_en      <= 1'b0;
            lcd_rs      <= 1'b0;
            busy        <= 1'b1;
        end else begin
            case (state)
                ST_POWERUP: begin
                    if (timer == '0) begin
                        state    <= ST_INIT;
                        phase    <= PH_SETUP;
                        byte_idx <= 4'd0;
                        lcd_rs   <= 1'b0;
                        lcd_data <= init_byte(4'd0);
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                ST_INIT, ST_REFRESH: begin
                    case (phase)
                        PH_SETUP: begin
                            lcd_en <= 1'b1;
                            timer  <= T_PULSE;
                            phase  <= PH_PULSE;
                        end
                        PH_PULSE: begin
                            if (timer == '0) begin
                                lcd_en <= 1'b0;
                                phase  <= PH_WAIT;
                                // The clear command needs the long wait.
                                timer  <= (!lcd_rs && lcd_data == 8'h01) ? T_CLEAR : T_CMD;
                            end else begin
                                timer <= timer - 1'b1;
                            end
                        end
                        PH_WAIT: begin
                            if (timer != '0) begin
                                timer <= timer - 1'b1;
                            end else if (last_byte) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                byte_idx <= next_idx;
                                phase    <= PH_SETUP;
                                lcd_rs   <= (state == ST_REFRESH);
                                lcd_data <= next_byte;
                            end
                        end
                        default: phase <= PH_SETUP;
                    endcase
                end

                ST_IDLE: begin
                    if (pending) begin
                        pending <= 1'b0;
                        if (!shown_valid || pend_val != shown_val) begin
                            shown_val   <= pend_val;
                            shown_valid <= 1'b1;
                            busy        <= 1'b1;
                            state       <= ST_REFRESH;
                            phase       <= PH_SETUP;
                            byte_idx    <= 4'd0;
                            lcd_rs      <= 1'b0;
                            lcd_data    <= 8'h80;
                        end
                    end
                end

                default: state <= ST_POWERUP;
            endcase

            // Capture comes last so a write in the accepting cycle is kept.
            if (write_en) begin
                pending  <= 1'b1;
                pend_val <= write_data;
            end
        end
    end

endmodule
